// File: rtl/demo_vector_checker.sv
// Sweeps all 32 {A,B,C,D,E} vectors, samples F at the end of each hold window and
// compares it against EXP_TABLE. Optional macro STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module demo_vector_checker #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [31:0] EXP_TABLE   = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  input  logic       F,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_cnt,
  output logic [4:0] cur_vec
);

  localparam int unsigned VEC_W  = 5;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned HOLD_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(31);

  logic [1:0]        state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [VEC_W-1:0]  stim_q, stim_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic              sample_c;
  logic              mism_c;
  logic              stop_c;
  logic [CNT_W-1:0]  err_inc_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      stim_q  <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      stim_q  <= stim_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Sample edge is the last cycle of the current vector's hold window.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    stim_d    = stim_q;
    hold_d    = hold_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;

    sample_c  = (state_q == S_RUN) && (hold_q == HOLD_LAST);
    mism_c    = (F != EXP_TABLE[vec_q]);
    err_inc_c = err_q + CNT_W'(mism_c);
`ifdef STOP_ON_FAIL_EN
    stop_c    = (vec_q == VEC_LAST) || mism_c;
`else
    stop_c    = (vec_q == VEC_LAST);
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          vec_d   = '0;
          stim_d  = '0;
          hold_d  = '0;
          err_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        hold_d = hold_q + HOLD_W'(1);
        if (sample_c) begin
          err_d = err_inc_c;
          if (stop_c) begin
            // The failing/last index stays visible on cur_vec; stimulus returns to 0.
            state_d = S_DONE;
            hold_d  = '0;
            stim_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_inc_c == '0);
          end else begin
            vec_d  = vec_q + VEC_W'(1);
            stim_d = vec_q + VEC_W'(1);
            hold_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        vec_d   = '0;
        stim_d  = '0;
        hold_d  = '0;
        err_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  assign {A, B, C, D, E} = stim_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign cur_vec         = vec_q;

endmodule

// File: tb/tb_demo_vector_checker.sv
// Randomized bench for demo_vector_checker: two instances (HOLD 10 and HOLD 2), each fed by a
// table-driven stand-in for demo01; results compared with a mismatch-count model.
module tb_demo_vector_checker;

  localparam int unsigned HOLD0 = 10;
  localparam int unsigned HOLD1 = 2;
  localparam logic [31:0] EXP0  = 32'hFFFF_0000;
  localparam logic [31:0] EXP1  = 32'hAAAA_AAAA;

  logic        clk;
  logic        rst_n;
  logic        start_r  [2];
  logic        f_w      [2];
  logic [31:0] resp_tbl [2];
  logic [4:0]  abcde_w  [2];
  logic        busy_w   [2];
  logic        done_w   [2];
  logic        pass_w   [2];
  logic [5:0]  err_w    [2];
  logic [4:0]  vec_w    [2];

  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar u = 0; u < 2; u++) begin : g_unit
    logic a, b, c, d, e;
    demo_vector_checker #(
      .HOLD_CYCLES(u == 0 ? HOLD0 : HOLD1),
      .EXP_TABLE  (u == 0 ? EXP0  : EXP1)
    ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start_r[u]),
      .A      (a),
      .B      (b),
      .C      (c),
      .D      (d),
      .E      (e),
      .F      (f_w[u]),
      .busy   (busy_w[u]),
      .done   (done_w[u]),
      .pass   (pass_w[u]),
      .err_cnt(err_w[u]),
      .cur_vec(vec_w[u])
    );
    assign abcde_w[u] = {a, b, c, d, e};
    // Combinational response, like demo01: F is a lookup of the applied vector.
    assign f_w[u] = resp_tbl[u][abcde_w[u]];
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle_reset(input int u);
    check_eq("rst_abcde", 32'(abcde_w[u]), 0);
    check_eq("rst_busy",  32'(busy_w[u]),  0);
    check_eq("rst_done",  32'(done_w[u]),  0);
    check_eq("rst_pass",  32'(pass_w[u]),  0);
    check_eq("rst_err",   32'(err_w[u]),   0);
    check_eq("rst_vec",   32'(vec_w[u]),   0);
  endtask

  // One full sweep; restart_at >= 0 pulses start again at that cycle of the sweep.
  task automatic run_sweep(input int u, input logic [31:0] resp, input int restart_at);
    int          hold;
    logic [31:0] exp_t;
    int          len, e_err, e_vec, first, cyc;
    hold  = (u == 0) ? int'(HOLD0) : int'(HOLD1);
    exp_t = (u == 0) ? EXP0 : EXP1;
    resp_tbl[u] = resp;
    e_err = 0;
    first = -1;
    for (int i = 0; i < 32; i++) begin
      if (resp[i] != exp_t[i]) begin
        e_err++;
        if (first < 0) first = i;
      end
    end
    len   = 32 * hold;
    e_vec = 31;
`ifdef STOP_ON_FAIL_EN
    if (first >= 0) begin
      len   = (first + 1) * hold;
      e_err = 1;
      e_vec = first;
    end
`endif
    @(negedge clk) start_r[u] = 1'b1;
    @(negedge clk) start_r[u] = 1'b0;
    cyc = 0;
    check_eq("start_busy", 32'(busy_w[u]), 1);
    check_eq("start_done", 32'(done_w[u]), 0);
    check_eq("start_pass", 32'(pass_w[u]), 0);
    check_eq("start_err",  32'(err_w[u]),  0);
    while (!done_w[u] && cyc < len + 20) begin
      if (cyc % hold == 0) check_eq("abcde_step", 32'(abcde_w[u]), cyc / hold);
      start_r[u] = (cyc == restart_at);
      @(negedge clk);
      cyc++;
    end
    start_r[u] = 1'b0;
    check_eq("sweep_len",  cyc, len);
    check_eq("end_err",    32'(err_w[u]),   e_err);
    check_eq("end_pass",   32'(pass_w[u]),  (e_err == 0) ? 1 : 0);
    check_eq("end_vec",    32'(vec_w[u]),   e_vec);
    check_eq("end_busy",   32'(busy_w[u]),  0);
    check_eq("end_abcde",  32'(abcde_w[u]), 0);
    // DONE must hold its results.
    repeat (5) @(negedge clk);
    check_eq("hold_done", 32'(done_w[u]), 1);
    check_eq("hold_err",  32'(err_w[u]),  e_err);
    check_eq("hold_vec",  32'(vec_w[u]),  e_vec);
  endtask

  task automatic reset_mid_sweep();
    @(negedge clk) start_r[0] = 1'b1;
    @(negedge clk) start_r[0] = 1'b0;
    repeat (99) @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy_w[0]), 1);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check_idle_reset(0);
    repeat (3) @(negedge clk);
    check_eq("post_rst_idle", 32'(busy_w[0]), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] tbl_a, tbl_e;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start_r[u]  = 1'b0;
      resp_tbl[u] = '0;
    end
    // F = A and F = E expressed as truth tables over vector index.
    for (int i = 0; i < 32; i++) begin
      tbl_a[i] = ((i >> 4) & 1) != 0;
      tbl_e[i] = (i & 1) != 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_reset(0);
    check_idle_reset(1);

    run_sweep(0, tbl_a, -1);
    run_sweep(0, 32'h0, -1);
    run_sweep(0, tbl_a, 50);
    reset_mid_sweep();
    run_sweep(0, tbl_a, -1);
    run_sweep(0, EXP0 ^ 32'h8000_0000, -1);
    run_sweep(0, EXP0 ^ 32'h0000_0001, -1);
    run_sweep(0, EXP0 ^ $urandom, -1);

    run_sweep(1, tbl_e, -1);
    run_sweep(1, EXP1 ^ 32'h8000_0000, -1);
    for (int k = 0; k < 4; k++) run_sweep(1, $urandom, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
